fb_draw_engine: RTL and testbench

Framebuffer draw engine: the execution stage directly downstream of the framebuffer display sequencer. Accepts one pixel instruction at a time over the start/finished dispatch handshake, decodes it, and performs the framebuffer memory access. The memory is a synchronous single-port RAM at a linear pixel address. Supports single-pixel draw, full-screen fill and pixel read-back, returning a result word on completion.

---
 rtl/fb_draw_engine_if.sv | 27 ++
 rtl/fb_draw_engine.sv | 166 ++++++++++++++++
 tb/tb_fb_draw_engine.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_draw_engine_if.sv
// Dispatch handshake plus framebuffer RAM port of the draw engine.
// The master side is the sequencer/RAM environment, the slave side is the engine.
interface fb_draw_engine_if #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int RESULT_WIDTH      = 32,
    parameter int ADDR_WIDTH        = 15,
    parameter int COLOR_WIDTH       = 3
);
    logic                         start;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         finished;
    logic [RESULT_WIDTH-1:0]      result;
    logic [ADDR_WIDTH-1:0]        fb_addr;
    logic [COLOR_WIDTH-1:0]       fb_wdata;
    logic                         fb_we;
    logic [COLOR_WIDTH-1:0]       fb_rdata;

    modport master (
        output start, instruction, fb_rdata,
        input  finished, result, fb_addr, fb_wdata, fb_we
    );

    modport slave (
        input  start, instruction, fb_rdata,
        output finished, result, fb_addr, fb_wdata, fb_we
    );
endinterface

// File: rtl/fb_draw_engine.sv
// Framebuffer draw engine: executes one DRAW / FILL / READ instruction at a
// time against a synchronous single-port framebuffer RAM.
//
// state      | meaning
// S_IDLE     | finished=1, waiting for start; latches the instruction
// S_DRAW     | single pixel write (when in range and enabled)
// S_FILL     | one write per cycle over the whole screen, ascending
// S_READ_ADDR| address presented to the RAM, fb_we=0
// S_READ_CAP | RAM read data captured
// S_DONE     | result loaded, back to idle
module fb_draw_engine #(
    parameter int OPCODE_WIDTH      = 4,
    parameter int X_WIDTH           = 8,
    parameter int Y_WIDTH           = 7,
    parameter int COLOR_WIDTH       = 3,
    parameter int SCREEN_WIDTH      = 160,
    parameter int SCREEN_HEIGHT     = 120,
    parameter int ADDR_WIDTH        = 15,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int RESULT_WIDTH      = 32
) (
    input  logic               clock,
    input  logic               resetn,
    fb_draw_engine_if.slave    bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DRAW      = 3'd1;
    localparam logic [2:0] S_FILL      = 3'd2;
    localparam logic [2:0] S_READ_ADDR = 3'd3;
    localparam logic [2:0] S_READ_CAP  = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [OPCODE_WIDTH-1:0] OP_DRAW = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_FILL = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_READ = OPCODE_WIDTH'(5);

    // Instruction field positions, packed LSB-first.
    localparam int X_LSB  = OPCODE_WIDTH;
    localparam int Y_LSB  = X_LSB + X_WIDTH;
    localparam int C_LSB  = Y_LSB + Y_WIDTH;
    localparam int EN_BIT = C_LSB + COLOR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] FILL_LAST = ADDR_WIDTH'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);
    localparam logic [RESULT_WIDTH-1:0] RESULT_ERR = {1'b1, {(RESULT_WIDTH-1){1'b0}}};

    logic [2:0]              r_state;
    logic [OPCODE_WIDTH-1:0] r_op;
    logic [X_WIDTH-1:0]      r_x;
    logic [Y_WIDTH-1:0]      r_y;
    logic [COLOR_WIDTH-1:0]  r_color;
    logic                    r_en;
    logic                    r_err;
    logic [COLOR_WIDTH-1:0]  r_rdata;
    logic [ADDR_WIDTH-1:0]   r_fill_cnt;
    logic [RESULT_WIDTH-1:0] r_result;

    logic [OPCODE_WIDTH-1:0] w_op;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_in_range;
    logic                    w_fb_we;
    logic [ADDR_WIDTH-1:0]   w_fb_addr;
    logic [COLOR_WIDTH-1:0]  w_fb_wdata;

    assign w_op       = bus.instruction[OPCODE_WIDTH-1:0];
    // Linear pixel address; arithmetic wraps naturally at ADDR_WIDTH.
    assign w_addr     = ADDR_WIDTH'(r_y) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(r_x);
    assign w_in_range = (32'(r_x) < SCREEN_WIDTH) && (32'(r_y) < SCREEN_HEIGHT);

    // Sequencing: accept in idle, execute, then publish the result in DONE.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_color    <= '0;
            r_en       <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_fill_cnt <= '0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op       <= w_op;
                        r_x        <= bus.instruction[X_LSB +: X_WIDTH];
                        r_y        <= bus.instruction[Y_LSB +: Y_WIDTH];
                        r_color    <= bus.instruction[C_LSB +: COLOR_WIDTH];
                        r_en       <= bus.instruction[EN_BIT];
                        r_err      <= 1'b0;
                        r_rdata    <= '0;
                        r_fill_cnt <= '0;
                        case (w_op)
                            OP_DRAW: r_state <= S_DRAW;
                            OP_FILL: r_state <= S_FILL;
                            OP_READ: r_state <= S_READ_ADDR;
                            default: begin
                                r_err   <= 1'b1;
                                r_state <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DRAW: begin
                    if (!w_in_range) r_err <= 1'b1;
                    r_state <= S_DONE;
                end
                S_FILL: begin
                    if (!r_en || r_fill_cnt == FILL_LAST) r_state <= S_DONE;
                    else r_fill_cnt <= r_fill_cnt + 1'b1;
                end
                S_READ_ADDR: begin
                    if (!w_in_range) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_READ_CAP;
                    end
                end
                S_READ_CAP: begin
                    r_rdata <= bus.fb_rdata;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (r_err)                r_result <= RESULT_ERR;
                    else if (r_op == OP_READ) r_result <= RESULT_WIDTH'(r_rdata);
                    else                      r_result <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM port decode from the current state; idle and done never touch memory.
    always_comb begin
        w_fb_we    = 1'b0;
        w_fb_addr  = '0;
        w_fb_wdata = '0;
        case (r_state)
            S_DRAW: begin
                if (w_in_range && r_en) begin
                    w_fb_we    = 1'b1;
                    w_fb_addr  = w_addr;
                    w_fb_wdata = r_color;
                end
            end
            S_FILL: begin
                if (r_en) begin
                    w_fb_we    = 1'b1;
                    w_fb_addr  = r_fill_cnt;
                    w_fb_wdata = r_color;
                end
            end
            S_READ_ADDR: w_fb_addr = w_addr;
            default: ;
        endcase
    end

    assign bus.fb_we    = w_fb_we;
    assign bus.fb_addr  = w_fb_addr;
    assign bus.fb_wdata = w_fb_wdata;
    assign bus.finished = (r_state == S_IDLE);
    assign bus.result   = r_result;
endmodule

// File: tb/tb_fb_draw_engine.sv
// Self-checking bench for fb_draw_engine: directed cases plus randomized
// instructions compared against a behavioural pixel/memory model.
module tb_fb_draw_engine;
    localparam logic [31:0] ERR = 32'h8000_0000;

    typedef struct {
        int c;
        int a;
        int d;
    } wr_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [2:0]  pre_data = '0;
    logic [2:0]  mem [0:32767];
    int          ref_mem [0:32767];
    wr_t         wq [$];

    fb_draw_engine_if bus ();

    fb_draw_engine dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Framebuffer RAM: synchronous single port, plus a bench-only preload port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.fb_we === 1'b1) mem[bus.fb_addr] <= bus.fb_wdata;
        bus.fb_rdata <= mem[bus.fb_addr];
    end

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.fb_we === 1'b1) begin
            wr_t w;
            w.c = cyc;
            w.a = int'(bus.fb_addr);
            w.d = int'(bus.fb_wdata);
            wq.push_back(w);
        end
    end

    function automatic logic [31:0] mk_instr(input int op, input int x, input int y,
                                             input int c, input int en, input int upper);
        logic [31:0] v;
        v = '0;
        v[3:0]   = op[3:0];
        v[11:4]  = x[7:0];
        v[18:12] = y[6:0];
        v[21:19] = c[2:0];
        v[22]    = en[0];
        v[31:23] = upper[8:0];
        return v;
    endfunction

    // Reference behaviour of a single DRAW/READ/unknown instruction.
    function automatic void model_op(input int op, input int x, input int y, input int c,
                                     input int en, output int has_w, output int a,
                                     output int d, output logic [31:0] res, output int lat);
        bit inr;
        inr = (x < 160) && (y < 120);
        has_w = 0; a = 0; d = 0; res = 32'h0; lat = 0;
        if (op == 3) begin
            lat = 3;
            if (!inr) res = ERR;
            else if (en != 0) begin
                has_w = 1;
                a = (y * 160 + x) % 32768;
                d = c;
                ref_mem[a] = c;
            end
        end else if (op == 5) begin
            if (!inr) begin
                res = ERR;
                lat = 3;
            end else begin
                res = 32'(ref_mem[y * 160 + x]);
                lat = 4;
            end
        end else begin
            res = ERR;
            lat = 2;
        end
    endfunction

    task automatic poke(input int addr, input int data);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = addr[14:0]; pre_data = data[2:0];
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_mem[addr] = data;
    endtask

    // Issue one instruction and wait (bounded) for finished; lat=-1 on timeout.
    task automatic run_op(input logic [31:0] instr, input bit hold2, input int budget,
                          output int lat, output int t0);
        @(posedge clk); #1;
        wq.delete();
        t0 = cyc;
        bus.instruction = instr;
        bus.start = 1'b1;
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (k == 1 && !hold2) bus.start = 1'b0;
            if (k == 2) bus.start = 1'b0;
            if (bus.finished === 1'b1) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.finished !== 1'b1) begin errors++; $display("FAIL reset_finished got=%b exp=1", bus.finished); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", bus.fb_we); end
        checks++; if (bus.fb_addr !== 15'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", bus.fb_addr); end
        checks++; if (bus.fb_wdata !== 3'd0) begin errors++; $display("FAIL reset_wdata got=%0d exp=0", bus.fb_wdata); end
        resetn = 1'b1;
    endtask

    task automatic test_draw();
        int lat, t0;
        run_op(mk_instr(3, 5, 2, 7, 1, 0), 1'b1, 50, lat, t0);
        ref_mem[325] = 7;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (lat !== 3) begin errors++; $display("FAIL draw_latency got=%0d exp=3", lat); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL draw_result got=%h exp=0", bus.result); end
        checks++; if (wq.size() !== 1) begin errors++; $display("FAIL draw_write_count got=%0d exp=1", wq.size()); end
        if (wq.size() > 0) begin
            checks++; if (wq[0].c !== t0 + 1) begin errors++; $display("FAIL draw_write_cycle got=%0d exp=%0d", wq[0].c - t0, 1); end
            checks++; if (wq[0].a !== 325) begin errors++; $display("FAIL draw_addr got=%0d exp=325", wq[0].a); end
            checks++; if (wq[0].d !== 7) begin errors++; $display("FAIL draw_data got=%0d exp=7", wq[0].d); end
        end
        checks++; if (bus.finished !== 1'b1) begin errors++; $display("FAIL draw_no_retrigger got=%b exp=1", bus.finished); end
    endtask

    task automatic test_draw_edges();
        int lat, t0;
        run_op(mk_instr(3, 159, 119, 6, 1, 0), 1'b0, 50, lat, t0);
        ref_mem[19199] = 6;
        checks++; if (wq.size() !== 1) begin errors++; $display("FAIL corner_count got=%0d exp=1", wq.size()); end
        if (wq.size() > 0) begin
            checks++; if (wq[0].a !== 19199) begin errors++; $display("FAIL corner_addr got=%0d exp=19199", wq[0].a); end
        end
        run_op(mk_instr(3, 160, 0, 3, 1, 0), 1'b0, 50, lat, t0);
        checks++; if (wq.size() !== 0) begin errors++; $display("FAIL oor_count got=%0d exp=0", wq.size()); end
        checks++; if (bus.result !== ERR) begin errors++; $display("FAIL oor_result got=%h exp=%h", bus.result, ERR); end
        run_op(mk_instr(3, 10, 10, 3, 0, 0), 1'b0, 50, lat, t0);
        checks++; if (wq.size() !== 0) begin errors++; $display("FAIL disabled_count got=%0d exp=0", wq.size()); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL disabled_result got=%h exp=0", bus.result); end
    endtask

    task automatic test_read();
        int lat, t0;
        poke(325, 5);
        run_op(mk_instr(5, 5, 2, 0, 0, 0), 1'b1, 50, lat, t0);
        checks++; if (lat !== 4) begin errors++; $display("FAIL read_latency got=%0d exp=4", lat); end
        checks++; if (bus.result !== 32'h5) begin errors++; $display("FAIL read_result got=%h exp=5", bus.result); end
        checks++; if (wq.size() !== 0) begin errors++; $display("FAIL read_writes got=%0d exp=0", wq.size()); end
    endtask

    task automatic test_unknown();
        int lat, t0;
        run_op(mk_instr(9, 5, 2, 7, 1, 0), 1'b1, 50, lat, t0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (lat !== 2) begin errors++; $display("FAIL unknown_latency got=%0d exp=2", lat); end
        checks++; if (bus.result !== ERR) begin errors++; $display("FAIL unknown_result got=%h exp=%h", bus.result, ERR); end
        checks++; if (wq.size() !== 0) begin errors++; $display("FAIL unknown_writes got=%0d exp=0", wq.size()); end
        checks++; if (bus.finished !== 1'b1) begin errors++; $display("FAIL unknown_once got=%b exp=1", bus.finished); end
    endtask

    task automatic test_fill();
        int lat, t0, bad;
        run_op(mk_instr(4, 77, 33, 2, 1, 0), 1'b1, 20000, lat, t0);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].a != i || wq[i].d != 2 || wq[i].c != t0 + 1 + i) bad++;
        for (int i = 0; i < 19200; i++) ref_mem[i] = 2;
        checks++; if (lat !== 19202) begin errors++; $display("FAIL fill_latency got=%0d exp=19202", lat); end
        checks++; if (wq.size() !== 19200) begin errors++; $display("FAIL fill_count got=%0d exp=19200", wq.size()); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL fill_sequence bad_entries=%0d exp=0", bad); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL fill_result got=%h exp=0", bus.result); end
        run_op(mk_instr(4, 0, 0, 6, 0, 0), 1'b0, 50, lat, t0);
        checks++; if (wq.size() !== 0) begin errors++; $display("FAIL fill_disabled_writes got=%0d exp=0", wq.size()); end
        checks++; if (lat < 0) begin errors++; $display("FAIL fill_disabled_timeout got=%0d exp=done", lat); end
    endtask

    task automatic test_random();
        int lat, t0, op, x, y, c, en, has_w, ea, ed, elat, sel;
        logic [31:0] eres;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) op = 3;
            else if (sel == 1) op = 5;
            else begin
                op = $urandom_range(0, 12);
                if (op >= 3) op = op + 3;
            end
            x  = $urandom_range(0, 170);
            y  = $urandom_range(0, 127);
            c  = $urandom_range(0, 7);
            en = $urandom_range(0, 3) != 0 ? 1 : 0;
            model_op(op, x, y, c, en, has_w, ea, ed, eres, elat);
            run_op(mk_instr(op, x, y, c, en, int'($urandom)), $urandom_range(0, 1) == 1, 50, lat, t0);
            checks++; if (lat !== elat) begin errors++; $display("FAIL rnd_latency n=%0d op=%0d got=%0d exp=%0d", n, op, lat, elat); end
            checks++; if (bus.result !== eres) begin errors++; $display("FAIL rnd_result n=%0d op=%0d got=%h exp=%h", n, op, bus.result, eres); end
            checks++; if (wq.size() !== has_w) begin errors++; $display("FAIL rnd_write_count n=%0d got=%0d exp=%0d", n, wq.size(), has_w); end
            if (has_w == 1 && wq.size() == 1) begin
                checks++;
                if (wq[0].a !== ea || wq[0].d !== ed || wq[0].c !== t0 + 1) begin
                    errors++;
                    $display("FAIL rnd_write n=%0d got=%0d/%0d@%0d exp=%0d/%0d@1", n, wq[0].a, wq[0].d, wq[0].c - t0, ea, ed);
                end
            end
        end
    endtask

    task automatic test_fill_abort();
        int lat, t0, last, has_w, ea, ed, elat;
        logic [31:0] eres;
        @(posedge clk); #1;
        wq.delete();
        t0 = cyc;
        bus.instruction = mk_instr(4, 0, 0, 5, 1, 0);
        bus.start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.start = 1'b0;
        end
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) ref_mem[i] = 5;
        checks++; if (bus.finished !== 1'b1) begin errors++; $display("FAIL abort_finished got=%b exp=1", bus.finished); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL abort_result got=%h exp=0", bus.result); end
        repeat (5) @(posedge clk);
        #1;
        last = (wq.size() > 0) ? wq[wq.size() - 1].c - t0 : 0;
        checks++; if (wq.size() !== 100) begin errors++; $display("FAIL abort_write_count got=%0d exp=100", wq.size()); end
        checks++; if (last > 100) begin errors++; $display("FAIL abort_last_write got=%0d exp<=100", last); end
        model_op(3, 1, 0, 3, 1, has_w, ea, ed, eres, elat);
        run_op(mk_instr(3, 1, 0, 3, 1, 0), 1'b1, 50, lat, t0);
        checks++;
        if (wq.size() !== 1 || lat !== elat || bus.result !== eres) begin
            errors++;
            $display("FAIL post_abort_draw writes=%0d lat=%0d res=%h exp 1/%0d/%h", wq.size(), lat, bus.result, elat, eres);
        end
        model_op(5, 50, 0, 0, 0, has_w, ea, ed, eres, elat);
        run_op(mk_instr(5, 50, 0, 0, 0, 0), 1'b0, 50, lat, t0);
        checks++; if (bus.result !== eres) begin errors++; $display("FAIL post_abort_read got=%h exp=%h", bus.result, eres); end
        model_op(5, 0, 1, 0, 0, has_w, ea, ed, eres, elat);
        run_op(mk_instr(5, 0, 1, 0, 0, 0), 1'b0, 50, lat, t0);
        checks++; if (bus.result !== eres) begin errors++; $display("FAIL post_abort_untouched got=%h exp=%h", bus.result, eres); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.instruction = '0;
        for (int i = 0; i < 32768; i++) ref_mem[i] = 0;
        test_reset();
        test_draw();
        test_draw_edges();
        test_read();
        test_unknown();
        test_fill();
        test_random();
        test_fill_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
